// File: rtl/uart_rx_buffer.sv
// Receive-side word FIFO between the UART RX FSM and its consumer.
// Registered one-cycle read path, occupancy flags from a registered count, and a sticky overflow flag.
module uart_rx_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int AF_LEVEL   = 6,
  localparam int AW        = $clog2(DEPTH),
  localparam int CW        = AW + 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  data_valid,
  input  logic                  rd_en,
  input  logic                  clr_ovf,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_full,
  output logic [CW-1:0]         count,
  output logic                  ovf
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wp, rp;
  logic                  rd_acc, wr_acc, drop;

  assign empty       = (count == '0);
  assign full        = (count == CW'(DEPTH));
  assign almost_full = (count >= CW'(AF_LEVEL));

  // A pop frees a slot in the same edge, so a full FIFO still takes a write alongside a read.
  assign rd_acc = rd_en && !empty;
  assign wr_acc = data_valid && (!full || rd_acc);
  assign drop   = data_valid && full && !rd_acc;

  // Storage is left unreset; reads are gated by empty so stale entries never surface.
  always_ff @(posedge CLK) begin
    if (wr_acc) mem[wp] <= P_DATA;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wp       <= '0;
      rp       <= '0;
      count    <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      rd_valid <= rd_acc;
      if (rd_acc) begin
        rd_data <= mem[rp];
        rp      <= rp + AW'(1);
      end
      if (wr_acc) wp <= wp + AW'(1);
      if (wr_acc && !rd_acc)      count <= count + CW'(1);
      else if (rd_acc && !wr_acc) count <= count - CW'(1);
      // Drop outranks a simultaneous clear so no overflow event is ever lost.
      if (drop)         ovf <= 1'b1;
      else if (clr_ovf) ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_buffer.sv
// Bench for uart_rx_buffer: directed scenarios plus random traffic, all checked
// against a queue-based model of the FIFO rules.
module tb_uart_rx_buffer;
  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int AF    = 6;
  localparam int CW    = 4;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic [DW-1:0] P_DATA = '0;
  logic          data_valid = 1'b0, rd_en = 1'b0, clr_ovf = 1'b0;
  logic [DW-1:0] rd_data;
  logic          rd_valid, empty, full, almost_full, ovf;
  logic [CW-1:0] count;

  uart_rx_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_LEVEL(AF)) dut (
    .CLK(CLK), .RST(RST), .P_DATA(P_DATA), .data_valid(data_valid), .rd_en(rd_en),
    .clr_ovf(clr_ovf), .rd_data(rd_data), .rd_valid(rd_valid), .empty(empty),
    .full(full), .almost_full(almost_full), .count(count), .ovf(ovf)
  );

  always #5 CLK = ~CLK;

  int            n_vec = 0, n_err = 0;
  logic [DW-1:0] q[$];
  logic [DW-1:0] m_rd = '0;
  logic          m_rv = 1'b0, m_ovf = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("rd_valid", 32'(rd_valid), 32'(m_rv));
    chk("rd_data", 32'(rd_data), 32'(m_rd));
    chk("count", 32'(count), 32'(q.size()));
    chk("empty", 32'(empty), 32'(q.size() == 0));
    chk("full", 32'(full), 32'(q.size() == DEPTH));
    chk("almost_full", 32'(almost_full), 32'(q.size() >= AF));
    chk("ovf", 32'(ovf), 32'(m_ovf));
  endtask

  task automatic model_clear();
    q.delete();
    m_rd = '0; m_rv = 1'b0; m_ovf = 1'b0;
  endtask

  // One clock: drive at negedge, advance the model, compare just after posedge.
  task automatic step(input logic dv, input logic [DW-1:0] d, input logic re, input logic co);
    bit rd_ok, was_full, dropped;
    @(negedge CLK);
    data_valid = dv; P_DATA = d; rd_en = re; clr_ovf = co;
    was_full = (q.size() == DEPTH);
    rd_ok    = re && (q.size() != 0);
    dropped  = dv && was_full && !rd_ok;
    m_rv = rd_ok;
    if (rd_ok) m_rd = q.pop_front();
    if (dv && !dropped) q.push_back(d);
    if (dropped) m_ovf = 1'b1;
    else if (co) m_ovf = 1'b0;
    @(posedge CLK); #1;
    check_all();
  endtask

  task automatic async_reset();
    @(posedge CLK); #3;
    RST = 1'b0; data_valid = 1'b0; rd_en = 1'b0; clr_ovf = 1'b0;
    model_clear();
    #1;
    check_all();
    @(negedge CLK); RST = 1'b1;
  endtask

  initial begin
    #1 check_all();
    @(negedge CLK); RST = 1'b1;

    // two words in, two out
    step(1, 8'hA5, 0, 0); step(1, 8'h3C, 0, 0); step(0, 0, 0, 0);
    step(0, 0, 1, 0); step(0, 0, 1, 0);

    // fill past capacity, then drain
    for (int i = 0; i < DEPTH; i++) step(1, 8'(i), 0, 0);
    step(1, 8'hFF, 0, 0);
    for (int i = 0; i < DEPTH; i++) step(0, 0, 1, 0);

    // full with simultaneous write and read
    step(0, 0, 0, 1);
    for (int i = 0; i < DEPTH; i++) step(1, 8'(8'h10 + i), 0, 0);
    step(1, 8'h99, 1, 0);
    for (int i = 0; i < DEPTH; i++) step(0, 0, 1, 0);

    // reads on empty, then write+read while empty
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0);
    step(1, 8'h55, 1, 0); step(0, 0, 1, 0);

    // overflow set beats clear
    for (int i = 0; i < DEPTH; i++) step(1, 8'($urandom), 0, 0);
    step(1, 8'h01, 0, 0); step(1, 8'h02, 0, 1); step(0, 0, 0, 1);
    for (int i = 0; i < DEPTH; i++) step(0, 0, 1, 0);

    // pointer wrap with write/read pairs
    for (int i = 0; i < 20; i++) begin
      step(1, 8'($urandom), 0, 0);
      step(0, 0, 1, 0);
    end

    // random traffic
    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 99) < 60), 8'($urandom), ($urandom_range(0, 99) < 45),
           ($urandom_range(0, 19) == 0));

    // mid-operation asynchronous reset with stored words
    while (q.size() > 0) step(0, 0, 1, 0);
    for (int i = 0; i < 5; i++) step(1, 8'(8'hC0 + i), 0, 0);
    async_reset();
    step(1, 8'h77, 0, 0); step(0, 0, 1, 0); step(0, 0, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
